// File: rtl/logic_unit_pipe_if.sv
// Valid/ready bus for logic_unit_pipe: operand side, result side, flags and delivery counter.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;
  logic [CNT_W-1:0] res_count;

  // Producer/consumer environment side
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ones, res_count
  );

  // Logic unit side
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ones, res_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with a two-entry (main + skid) output stage,
// result flags and a wrapping delivered-result counter.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          areset,
  logic_unit_pipe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             ones;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  entry_t           main_q;
  entry_t           skid_q;
  entry_t           new_c;
  logic             ready_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] res_c;
  logic             accept_c;
  logic             deliver_c;

  // Operation decode; flags are bound to the result here and travel with it
  always_comb begin
    res_c = '0;
    case (bus.in_op)
      3'd0: res_c = ~bus.in_a;
      3'd1: res_c = bus.in_a & bus.in_b;
      3'd2: res_c = bus.in_a | bus.in_b;
      3'd3: res_c = bus.in_a ^ bus.in_b;
      3'd4: res_c = ~(bus.in_a & bus.in_b);
      3'd5: res_c = ~(bus.in_a | bus.in_b);
      3'd6: res_c = ~(bus.in_a ^ bus.in_b);
      3'd7: res_c = bus.in_a;
      default: res_c = '0;
    endcase
    new_c.data = res_c;
    new_c.zero = (res_c == '0);
    new_c.ones = (res_c == '1);
  end

  assign accept_c  = bus.in_valid && ready_q;
  assign deliver_c = valid_q && bus.out_ready;

  // Occupancy FSM; in_ready/out_valid are registered alongside the state
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (deliver_c) count_q <= count_q + CNT_W'(1);
      case (state)
        EMPTY: begin
          if (accept_c) begin
            main_q  <= new_c;
            valid_q <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept_c && deliver_c) begin
            main_q <= new_c;
          end else if (accept_c) begin
            skid_q  <= new_c;
            ready_q <= 1'b0;
            state   <= TWO;
          end else if (deliver_c) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (deliver_c) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = main_q.data;
  assign bus.out_zero  = main_q.zero;
  assign bus.out_ones  = main_q.ones;
  assign bus.res_count = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: truth-table reference model with a FIFO scoreboard.
module tb_logic_unit_pipe;

  // Per-opcode 2-input truth tables, indexed by {a_bit, b_bit}
  localparam logic [3:0] TT [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0110,
                                    4'b0111, 4'b0001, 4'b1001, 4'b1100};

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) b8();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(4))  b4();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut   (.clk(clk), .areset(areset), .bus(b8));
  logic_unit_pipe #(.WIDTH(8), .CNT_W(4))  dut_w (.clk(clk), .areset(areset), .bus(b4));

  int         ntests = 0;
  int         nfail  = 0;
  int         dcount = 0;
  logic [7:0] q[$];
  logic [7:0] obs[$];

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] tt;
    tt = TT[op];
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // One clock on the 8-bit DUT: handshakes predicted from the model, scoreboard updated after the edge
  task automatic tick();
    bit         acc;
    bit         del;
    logic [7:0] r;
    acc = b8.in_valid && (q.size() < 2);
    del = (q.size() != 0) && b8.out_ready;
    r   = ref_op(b8.in_op, b8.in_a, b8.in_b);
    if (b8.out_valid && b8.out_ready) obs.push_back(b8.out_data);
    @(posedge clk);
    @(negedge clk);
    if (del) begin
      void'(q.pop_front());
      dcount++;
    end
    if (acc) q.push_back(r);
  endtask

  task automatic test_reset();
    b8.in_valid = 1'b0; b8.in_op = 3'd0; b8.in_a = 8'h00; b8.in_b = 8'h00; b8.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.in_op = 3'd0; b4.in_a = 8'h00; b4.in_b = 8'h00; b4.out_ready = 1'b0;
    areset = 1'b1;
    #2;
    ntests++;
    if (b8.in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready got=%b exp=1", b8.in_ready); end
    ntests++;
    if (b8.out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got=%b exp=0", b8.out_valid); end
    ntests++;
    if ({b8.out_data, b8.out_zero, b8.out_ones} !== 10'h000) begin
      nfail++; $display("FAIL reset_out_bus got=%h/%b/%b exp=00/0/0", b8.out_data, b8.out_zero, b8.out_ones);
    end
    ntests++;
    if (b8.res_count !== 16'h0000) begin nfail++; $display("FAIL reset_res_count got=%h exp=0000", b8.res_count); end
    @(negedge clk);
    areset = 1'b0;
    q.delete(); obs.delete(); dcount = 0;
  endtask

  task automatic test_opcode_sweep();
    logic [7:0] exp_t [8];
    exp_t = '{8'h3C, 8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'hC3};
    b8.out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      b8.in_valid = 1'b1; b8.in_op = 3'(op); b8.in_a = 8'hC3; b8.in_b = 8'hA5;
      tick();
      ntests++;
      if (b8.out_valid !== 1'b1 || b8.out_data !== exp_t[op]) begin
        nfail++; $display("FAIL sweep_op%0d got=%b/%h exp=1/%h", op, b8.out_valid, b8.out_data, exp_t[op]);
      end
    end
    b8.in_valid = 1'b0;
    tick();
    ntests++;
    if (b8.res_count !== 16'd8) begin nfail++; $display("FAIL sweep_res_count got=%0d exp=8", b8.res_count); end
    ntests++;
    if (b8.out_valid !== 1'b0) begin nfail++; $display("FAIL sweep_drain got=%b exp=0", b8.out_valid); end
  endtask

  task automatic test_flags();
    b8.out_ready = 1'b1;
    b8.in_valid = 1'b1; b8.in_op = 3'd3; b8.in_a = 8'h5A; b8.in_b = 8'h5A;
    tick();
    ntests++;
    if ({b8.out_data, b8.out_zero, b8.out_ones} !== {8'h00, 1'b1, 1'b0}) begin
      nfail++; $display("FAIL flags_zero got=%h/%b/%b exp=00/1/0", b8.out_data, b8.out_zero, b8.out_ones);
    end
    b8.in_op = 3'd6;
    tick();
    ntests++;
    if ({b8.out_data, b8.out_zero, b8.out_ones} !== {8'hFF, 1'b0, 1'b1}) begin
      nfail++; $display("FAIL flags_ones got=%h/%b/%b exp=FF/0/1", b8.out_data, b8.out_zero, b8.out_ones);
    end
    b8.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] want [3];
    want = '{8'h11, 8'h22, 8'h33};
    obs.delete();
    b8.out_ready = 1'b0;
    b8.in_valid = 1'b1; b8.in_op = 3'd7; b8.in_b = 8'($urandom);
    b8.in_a = 8'h11; tick();
    ntests++;
    if (b8.in_ready !== 1'b1) begin nfail++; $display("FAIL bp_ready_after_1st got=%b exp=1", b8.in_ready); end
    b8.in_a = 8'h22; tick();
    b8.in_a = 8'h33;
    for (int i = 0; i < 3; i++) begin
      ntests++;
      if (b8.in_ready !== 1'b0 || b8.out_valid !== 1'b1 || b8.out_data !== 8'h11) begin
        nfail++; $display("FAIL bp_stall%0d got rdy=%b vld=%b data=%h exp rdy=0 vld=1 data=11",
                          i, b8.in_ready, b8.out_valid, b8.out_data);
      end
      tick();
    end
    b8.out_ready = 1'b1;
    tick();
    ntests++;
    if (b8.in_ready !== 1'b1 || b8.out_data !== 8'h22) begin
      nfail++; $display("FAIL bp_release got rdy=%b data=%h exp rdy=1 data=22", b8.in_ready, b8.out_data);
    end
    tick();
    b8.in_valid = 1'b0;
    tick();
    ntests++;
    if (obs.size() != 3) begin
      nfail++; $display("FAIL bp_order_count got=%0d exp=3", obs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        ntests++;
        if (obs[i] !== want[i]) begin nfail++; $display("FAIL bp_order%0d got=%h exp=%h", i, obs[i], want[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    start = dcount;
    b8.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b8.in_valid = 1'b1; b8.in_op = 3'($urandom); b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
      tick();
      ntests++;
      if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b1 || b8.out_data !== q[0] ||
          b8.out_zero !== (q[0] == 8'h00) || b8.out_ones !== (q[0] == 8'hFF)) begin
        nfail++; $display("FAIL b2b_%0d got rdy=%b data=%h z=%b o=%b exp rdy=1 data=%h",
                          i, b8.in_ready, b8.out_data, b8.out_zero, b8.out_ones, q[0]);
      end
    end
    b8.in_valid = 1'b0;
    tick();
    ntests++;
    if (b8.res_count !== 16'(start + 100)) begin
      nfail++; $display("FAIL b2b_res_count got=%0d exp=%0d", b8.res_count, start + 100);
    end
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < 300; i++) begin
      b8.in_valid = 1'($urandom); b8.out_ready = ($urandom_range(0, 3) != 0);
      b8.in_op = 3'($urandom); b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
      tick();
      ntests++;
      if (b8.out_valid !== (q.size() != 0) || b8.in_ready !== (q.size() < 2) || b8.res_count !== 16'(dcount)) begin
        nfail++; $display("FAIL rnd_ctrl_%0d got vld=%b rdy=%b cnt=%0d exp vld=%b rdy=%b cnt=%0d", i,
                          b8.out_valid, b8.in_ready, b8.res_count, q.size() != 0, q.size() < 2, dcount);
      end
      if (q.size() != 0) begin
        ntests++;
        if (b8.out_data !== q[0] || b8.out_zero !== (q[0] == 8'h00) || b8.out_ones !== (q[0] == 8'hFF)) begin
          nfail++; $display("FAIL rnd_data_%0d got=%h/%b/%b exp=%h", i, b8.out_data, b8.out_zero, b8.out_ones, q[0]);
        end
      end
    end
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    b8.out_ready = 1'b0;
    b8.in_valid = 1'b1; b8.in_op = 3'($urandom); b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
    tick(); tick();
    ntests++;
    if (b8.in_ready !== 1'b0 || b8.out_valid !== 1'b1) begin
      nfail++; $display("FAIL midrst_full got rdy=%b vld=%b exp rdy=0 vld=1", b8.in_ready, b8.out_valid);
    end
    b8.in_valid = 1'b0;
    #1 areset = 1'b1;
    #2 areset = 1'b0;
    #1;
    ntests++;
    if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.res_count !== 16'h0000 ||
        {b8.out_data, b8.out_zero, b8.out_ones} !== 10'h000) begin
      nfail++; $display("FAIL midrst_values got vld=%b rdy=%b cnt=%0d data=%h/%b/%b exp 0/1/0/00/0/0",
                        b8.out_valid, b8.in_ready, b8.res_count, b8.out_data, b8.out_zero, b8.out_ones);
    end
    q.delete(); obs.delete(); dcount = 0;
    b8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ntests++;
    if (obs.size() != 0 || b8.out_valid !== 1'b0 || b8.res_count !== 16'h0000) begin
      nfail++; $display("FAIL midrst_stale got deliveries=%0d vld=%b cnt=%0d exp 0/0/0",
                        obs.size(), b8.out_valid, b8.res_count);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] a0;
    b4.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b4.in_valid = 1'b1; b4.in_op = 3'd7; b4.in_a = 8'($urandom); b4.in_b = 8'($urandom);
      a0 = b4.in_a;
      @(posedge clk); @(negedge clk);
      if (i == 0) begin
        ntests++;
        if (b4.out_data !== a0) begin nfail++; $display("FAIL wrap_first_data got=%h exp=%h", b4.out_data, a0); end
      end
    end
    ntests++;
    if (b4.res_count !== 4'd0) begin nfail++; $display("FAIL wrap_at16 got=%0d exp=0", b4.res_count); end
    b4.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    ntests++;
    if (b4.res_count !== 4'd1) begin nfail++; $display("FAIL wrap_at17 got=%0d exp=1", b4.res_count); end
  endtask

  initial begin
    test_reset();
    test_opcode_sweep();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
